// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - valid/ready data-store responder for read/write/double/complement ops.
// Define MEM_RMW_EN to enable the double/complement datapath; otherwise those ops respond with rsp_err.
module mem_responder #(
  parameter int AW          = 4,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    cnt;
  logic [DW-1:0] mem [2**AW];

  logic          accept;
  logic [DW-1:0] cur;
  logic          ex_we;
  logic [DW-1:0] ex_data;
  logic          ex_err;

  assign accept = req_valid && req_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !RST;
        if (req_valid && !RST) state_nxt = (WAIT_STATES > 0) ? WAIT : EXEC;
      end
      WAIT: if (cnt == 3'd0) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operation result, computed from the latched request and the current word.
  always_comb begin
    cur     = mem[addr_q];
    ex_we   = 1'b0;
    ex_data = cur;
    ex_err  = 1'b0;
    case (op_q)
      2'b00: ;
      2'b01: begin
        ex_we   = 1'b1;
        ex_data = wdata_q;
      end
`ifdef MEM_RMW_EN
      2'b10: begin
        ex_we   = 1'b1;
        ex_data = {cur[DW-2:0], 1'b0};
      end
      default: begin
        ex_we   = 1'b1;
        ex_data = ~cur;
      end
`else
      default: begin
        ex_data = '0;
        ex_err  = 1'b1;
      end
`endif
    endcase
  end

  // Reset has priority, so an EXEC edge with RST high commits nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= 3'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem       <= '{default: '0};
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_LOAD;
      end
      if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == EXEC) begin
        rsp_rdata <= ex_data;
        rsp_err   <= ex_err;
        if (ex_we) mem[addr_q] <= ex_data;
      end
    end
  end

endmodule
